// File: rtl/touch_stroke_processor.sv
// Turns raw touch-panel samples into debounced pen strokes and palette colour picks.
// Strobe semantics: sample_valid qualifies one input sample; every pulse output lasts one cycle.
module touch_stroke_processor #(
  parameter int X_W           = 9,
  parameter int Y_W           = 8,
  parameter int NUM_COLORS    = 5,
  parameter int PAL_X_MIN     = 20,
  parameter int PAL_X_MAX     = 60,
  parameter int PAL_Y_MIN     = 20,
  parameter int SWATCH_H      = 40,
  parameter int DEBOUNCE      = 3,
  parameter int DEFAULT_COLOR = 0
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           sample_valid,
  input  logic           pressed,
  input  logic [X_W-1:0] x_in,
  input  logic [Y_W-1:0] y_in,
  output logic           pt_valid,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [2:0]     color_out,
  output logic           stroke_start,
  output logic           stroke_end,
  output logic           color_pick
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESS_PEND, S_DRAW, S_REL_PEND, S_PICK, S_PICK_REL
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d, cnt_inc;
  logic            deb_done;
  logic [X_W-1:0]  last_x, last_x_d, x_d;
  logic [Y_W-1:0]  last_y, last_y_d, y_d;
  logic [2:0]      color_d;
  logic            pt_d, start_d, end_d, pick_d;
  logic [31:0]     x_ext, y_ext;
  logic            in_pal, dup;
  logic [NUM_COLORS-1:0] ge;
  logic [2:0]      swatch_idx;

  assign x_ext = 32'(x_in);
  assign y_ext = 32'(y_in);

  assign in_pal = (x_ext > 32'(PAL_X_MIN)) && (x_ext < 32'(PAL_X_MAX)) &&
                  (y_ext > 32'(PAL_Y_MIN)) &&
                  (y_ext < 32'(PAL_Y_MIN + NUM_COLORS * SWATCH_H));

  // One comparator per swatch top edge; the highest edge passed wins.
  for (genvar g = 0; g < NUM_COLORS; g++) begin : g_swatch
    assign ge[g] = (y_ext >= 32'(PAL_Y_MIN + g * SWATCH_H));
  end

  always_comb begin
    swatch_idx = '0;
    for (int i = 0; i < NUM_COLORS; i++)
      if (ge[i]) swatch_idx = 3'(i);
  end

  assign dup      = (x_in == last_x) && (y_in == last_y);
  assign cnt_inc  = cnt + CW'(1);
  // cnt is always 0 when entering a pending phase, so cnt_inc covers the DEBOUNCE=1 case too.
  assign deb_done = (cnt_inc == CW'(DEBOUNCE));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (sample_valid) begin
      unique case (state)
        S_IDLE, S_PRESS_PEND: begin
          if (!pressed) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (deb_done) begin
            state_d = in_pal ? S_PICK : S_DRAW;
            cnt_d   = '0;
          end else begin
            state_d = S_PRESS_PEND;
            cnt_d   = cnt_inc;
          end
        end
        S_DRAW, S_REL_PEND: begin
          if (pressed) begin
            state_d = S_DRAW;
            cnt_d   = '0;
          end else if (deb_done) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_REL_PEND;
            cnt_d   = cnt_inc;
          end
        end
        S_PICK, S_PICK_REL: begin
          if (pressed) begin
            state_d = S_PICK;
            cnt_d   = '0;
          end else if (deb_done) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = S_PICK_REL;
            cnt_d   = cnt_inc;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pt_d     = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    pick_d   = 1'b0;
    x_d      = x_out;
    y_d      = y_out;
    color_d  = color_out;
    last_x_d = last_x;
    last_y_d = last_y;
    if (sample_valid) begin
      unique case (state)
        S_IDLE, S_PRESS_PEND: begin
          if (pressed && deb_done) begin
            if (in_pal) begin
              color_d = swatch_idx;
              pick_d  = 1'b1;
            end else begin
              pt_d     = 1'b1;
              start_d  = 1'b1;
              x_d      = x_in;
              y_d      = y_in;
              last_x_d = x_in;
              last_y_d = y_in;
            end
          end
        end
        S_DRAW, S_REL_PEND: begin
          if (pressed) begin
            if (!in_pal && !dup) begin
              pt_d     = 1'b1;
              x_d      = x_in;
              y_d      = y_in;
              last_x_d = x_in;
              last_y_d = y_in;
            end
          end else if (deb_done) begin
            end_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pt_valid     <= 1'b0;
      stroke_start <= 1'b0;
      stroke_end   <= 1'b0;
      color_pick   <= 1'b0;
      x_out        <= '0;
      y_out        <= '0;
      color_out    <= 3'(DEFAULT_COLOR);
      last_x       <= '0;
      last_y       <= '0;
    end else begin
      pt_valid     <= pt_d;
      stroke_start <= start_d;
      stroke_end   <= end_d;
      color_pick   <= pick_d;
      x_out        <= x_d;
      y_out        <= y_d;
      color_out    <= color_d;
      last_x       <= last_x_d;
      last_y       <= last_y_d;
    end
  end

endmodule

// File: tb/tb_touch_stroke_processor.sv
// Bench for touch_stroke_processor: directed scenarios then random touch traffic,
// checked against a run-length model of press/release debounce.
module tb_touch_stroke_processor;

  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int NUM_COLORS = 5;
  localparam int PAL_X_MIN = 20;
  localparam int PAL_X_MAX = 60;
  localparam int PAL_Y_MIN = 20;
  localparam int SWATCH_H = 40;
  localparam int DEBOUNCE = 3;
  localparam int DEFAULT_COLOR = 0;
  localparam int W = 4 + 3 + X_W + Y_W;

  logic           clk_in = 1'b0;
  logic           rst_n_in;
  logic           sample_valid;
  logic           pressed;
  logic [X_W-1:0] x_in;
  logic [Y_W-1:0] y_in;
  logic           pt_valid;
  logic [X_W-1:0] x_out;
  logic [Y_W-1:0] y_out;
  logic [2:0]     color_out;
  logic           stroke_start;
  logic           stroke_end;
  logic           color_pick;

  touch_stroke_processor #(
    .X_W(X_W), .Y_W(Y_W), .NUM_COLORS(NUM_COLORS), .PAL_X_MIN(PAL_X_MIN),
    .PAL_X_MAX(PAL_X_MAX), .PAL_Y_MIN(PAL_Y_MIN), .SWATCH_H(SWATCH_H),
    .DEBOUNCE(DEBOUNCE), .DEFAULT_COLOR(DEFAULT_COLOR)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_valid(sample_valid),
    .pressed(pressed), .x_in(x_in), .y_in(y_in), .pt_valid(pt_valid),
    .x_out(x_out), .y_out(y_out), .color_out(color_out),
    .stroke_start(stroke_start), .stroke_end(stroke_end), .color_pick(color_pick)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: debounced contact level plus the length of the current disagreeing run.
  bit           m_contact;
  bit           m_is_pick;
  int           m_run;
  logic [X_W-1:0] m_lx, m_xo;
  logic [Y_W-1:0] m_ly, m_yo;
  logic [2:0]   m_color;
  bit           m_pt, m_start, m_end, m_pick;

  function automatic bit pal_hit(input int x, input int y);
    return (x > PAL_X_MIN) && (x < PAL_X_MAX) && (y > PAL_Y_MIN) &&
           (y < PAL_Y_MIN + NUM_COLORS * SWATCH_H);
  endfunction

  function automatic int swatch_of(input int y);
    int s;
    s = (y - PAL_Y_MIN) / SWATCH_H;
    if (s > NUM_COLORS - 1) s = NUM_COLORS - 1;
    if (s < 0) s = 0;
    return s;
  endfunction

  task automatic model_reset();
    m_contact = 0; m_is_pick = 0; m_run = 0;
    m_lx = '0; m_ly = '0; m_xo = '0; m_yo = '0;
    m_color = 3'(DEFAULT_COLOR);
    m_pt = 0; m_start = 0; m_end = 0; m_pick = 0;
    exp_q.delete();
  endtask

  task automatic emit_point(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    m_pt = 1; m_xo = x; m_yo = y; m_lx = x; m_ly = y;
  endtask

  task automatic model_step(input bit v, input bit p, input logic [X_W-1:0] x,
                            input logic [Y_W-1:0] y);
    m_pt = 0; m_start = 0; m_end = 0; m_pick = 0;
    if (!v) return;
    if (p != m_contact) begin
      m_run++;
      if (m_run == DEBOUNCE) begin
        m_run = 0;
        m_contact = p;
        if (p) begin
          m_is_pick = pal_hit(x, y);
          if (m_is_pick) begin
            m_color = 3'(swatch_of(y));
            m_pick = 1;
          end else begin
            emit_point(x, y);
            m_start = 1;
          end
        end else if (!m_is_pick) begin
          m_end = 1;
        end
      end
    end else begin
      m_run = 0;
      if (p && !m_is_pick && !pal_hit(x, y) && !(x == m_lx && y == m_ly))
        emit_point(x, y);
    end
  endtask

  // Driver: one clock of stimulus, then compare registered outputs after the edge.
  task automatic cycle(input bit v, input bit p, input int x, input int y);
    logic [W-1:0] e;
    @(negedge clk_in);
    sample_valid = v;
    pressed = p;
    x_in = X_W'(x);
    y_in = Y_W'(y);
    model_step(v, p, X_W'(x), Y_W'(y));
    exp_q.push_back({m_pt, m_start, m_end, m_pick, m_color, m_xo, m_yo});
    @(posedge clk_in);
    #1;
    e = exp_q.pop_front();
    check("pt_valid", 32'(pt_valid), 32'(e[W-1]));
    check("stroke_start", 32'(stroke_start), 32'(e[W-2]));
    check("stroke_end", 32'(stroke_end), 32'(e[W-3]));
    check("color_pick", 32'(color_pick), 32'(e[W-4]));
    check("color_out", 32'(color_out), 32'(e[X_W+Y_W+:3]));
    check("x_out", 32'(x_out), 32'(e[Y_W+:X_W]));
    check("y_out", 32'(y_out), 32'(e[0+:Y_W]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pt"}, 32'(pt_valid), 0);
    check({tag, "_start"}, 32'(stroke_start), 0);
    check({tag, "_end"}, 32'(stroke_end), 0);
    check({tag, "_pick"}, 32'(color_pick), 0);
    check({tag, "_x"}, 32'(x_out), 0);
    check({tag, "_y"}, 32'(y_out), 0);
    check({tag, "_color"}, 32'(color_out), DEFAULT_COLOR);
  endtask

  task automatic apply_reset();
    sample_valid = 0; pressed = 0; x_in = '0; y_in = '0;
    rst_n_in = 0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_in);
    rst_n_in = 1;
  endtask

  initial begin
    bit intent;
    bit v, p;
    int x, y;

    apply_reset();

    // Debounced press on the canvas starts a stroke
    repeat (3) cycle(1, 1, 100, 50);
    check("t1_pt", 32'(pt_valid), 1);
    check("t1_start", 32'(stroke_start), 1);
    check("t1_x", 32'(x_out), 100);
    check("t1_y", 32'(y_out), 50);
    check("t1_color", 32'(color_out), 0);

    // Duplicate suppression
    cycle(1, 1, 100, 50);
    check("t3_dup", 32'(pt_valid), 0);
    cycle(1, 1, 100, 50);
    cycle(1, 1, 101, 50);
    check("t3_pt", 32'(pt_valid), 1);
    check("t3_x", 32'(x_out), 101);

    // Release bounce keeps the stroke, then a real release ends it
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("t4_no_end", 32'(stroke_end), 0);
    cycle(1, 1, 102, 50);
    check("t4_pt", 32'(pt_valid), 1);
    check("t4_x", 32'(x_out), 102);
    repeat (2) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    check("t4_end", 32'(stroke_end), 1);
    cycle(1, 0, 0, 0);

    // Palette pick, held swatch change ignored, release has no stroke_end
    repeat (3) cycle(1, 1, 40, 110);
    check("t2_pick", 32'(color_pick), 1);
    check("t2_color", 32'(color_out), 2);
    check("t2_no_pt", 32'(pt_valid), 0);
    repeat (2) cycle(1, 1, 40, 150);
    check("t2_hold_color", 32'(color_out), 2);
    repeat (3) cycle(1, 0, 0, 0);
    check("t2_no_end", 32'(stroke_end), 0);

    // Dragging into the palette; palette edges count as canvas
    repeat (3) cycle(1, 1, 100, 50);
    cycle(1, 1, 40, 70);
    check("t5_pal_drag", 32'(pt_valid), 0);
    check("t5_color", 32'(color_out), 2);
    cycle(1, 1, 40, 20);
    check("t5_edge_y20", 32'(pt_valid), 1);
    cycle(1, 1, 40, 220);
    check("t5_edge_y220", 32'(pt_valid), 1);
    cycle(1, 1, 60, 100);
    check("t5_edge_x60", 32'(pt_valid), 1);
    cycle(1, 1, 61, 100);

    // Asynchronous reset mid-stroke
    @(negedge clk_in);
    #2;
    rst_n_in = 0;
    #1;
    check_reset_outputs("t6_async");
    model_reset();
    sample_valid = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1;
    repeat (2) cycle(1, 1, 100, 50);
    check("t6_quiet", 32'(pt_valid), 0);
    cycle(1, 0, 0, 0);

    // Random touch traffic with bounce, gaps, duplicates and palette hits
    intent = 0;
    x = 100; y = 50;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) intent = ~intent;
      v = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 6) == 0) ? ~intent : intent;
      case ($urandom_range(0, 5))
        0, 1: ;
        2: begin x = x + $urandom_range(0, 2) - 1; y = y + $urandom_range(0, 2) - 1; end
        3: begin x = $urandom_range(15, 65); y = $urandom_range(15, 225); end
        4: begin x = $urandom_range(0, 511); y = $urandom_range(0, 255); end
        default: begin x = $urandom_range(0, 2) * 20 + 20; y = $urandom_range(0, 5) * 40 + 20; end
      endcase
      if (x < 0) x = 0;
      if (x > 511) x = 511;
      if (y < 0) y = 0;
      if (y > 255) y = 255;
      cycle(v, p, x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
